linebuffer_2x2_multich: RTL and testbench
=========================================

// Module: linebuffer_2x2_multich
// PURPOSE
//  Parametrised multi-channel 2x2 sliding-window generator for the int4 CNN datapath.
//  Row length is set at runtime, replacing the fixed six-length select. Adds pixel-valid
//  qualification, row/column tracking, a per-window valid strobe and stride-1/stride-2 mode.
//  Sits between the conv/activation stream and the 2x2 pool/conv stages; one instance covers all channels.
// PARAMETERS
//  CH       8    parallel channels (streams) sharing one control path
//  DW       4    bits per pixel per channel
//  MAX_LEN  224  largest supported row length (line-buffer depth)
//  LEN_W    8    width of row_len; must satisfy 2**LEN_W > MAX_LEN
// PORTS
//  clk        in   1         rising-edge clock
//  rst        in   1         asynchronous, active-high reset
//  row_len    in   LEN_W     feature-map width W (frame is W x W); sampled at frame start
//  stride2    in   1         1 = non-overlapping windows (pooling), 0 = every position; sampled at frame start
//  in_valid   in   1         pixel present on ifm_in this cycle
//  ifm_in     in   CH*DW     channel c at [c*DW +: DW]
//  win_valid  out  1         ifm_win carries a valid window this cycle
//  ifm_win    out  CH*4*DW   per channel c, [c*4*DW +: 4*DW] = {TL,TR,BL,BR}, TL in MSBs
//  win_row    out  LEN_W     row index of BR pixel for the current window
//  win_col    out  LEN_W     column index of BR pixel for the current window
// BEHAVIOUR
//  - Reset: win_valid=0, ifm_win=0, win_row=0, win_col=0, counters=0, cfg regs = MAX_LEN / 0. Line-buffer contents are don't-care.
//  - Streaming only, no backpressure. in_valid=0 freezes counters, line buffer and window registers; win_valid=0 that cycle.
//  - Config latch: row_len/stride2 are captured into cfg regs when a pixel is accepted at (row 0, col 0).
//    Mid-frame changes are ignored. Captured row_len<2 clamps to 2; >MAX_LEN clamps to MAX_LEN.
//  - Counters: col 0..L-1 wraps to 0 and increments row. row 0..L-1 wraps to 0, which starts a new frame.
//  - Line buffer: delay of exactly L accepted pixels, CH*DW wide, so the top row aligns with the incoming bottom row.
//  - Window: TL/TR = buffered pixels (row-1, col-1)/(row-1, col); BL/BR = (row, col-1)/(row, col).
//  - Valid rule for pixel accepted at (r,c): stride2=0 -> r>=1 && c>=1; stride2=1 -> r odd && c odd.
//  - Latency: window outputs are registered and appear the cycle after the accepted BR pixel.
//    win_row/win_col = (r,c) of that pixel. Pixels at c=0 never form a window, so no row-wrap windows.
//  - Odd L with stride2=1: the last column/row is dropped (floor semantics).
//  - Reset mid-frame: counters clear immediately and the next pixel is (0,0) of a new frame.
//    No window may use pre-reset data; this is guaranteed by the r>=1 rule.
//  - ifm_win holds its last value while win_valid=0.
// CONFIGURATION
//  LB2X2_FRAME_END_EN: when defined, adds output port frame_end (1 bit, reset 0).
//    frame_end pulses with win_valid for the window whose BR pixel is at (L-1,L-1),
//    or at (L-2,L-2) for stride2 with odd L.
//  Without the macro, the port does not exist and no end-of-frame logic is built.
// STRUCTURE
//  Package lb2x2_pkg: window slot offsets (TL=3,TR=2,BL=1,BR=0), clamp helper function, LEN_W check constant.
//  Sub-module linebuffer_row_delay: runtime-length delay line (MAX_LEN x CH*DW RAM with a wrapping pointer,
//    ptr wraps at L-1) with enable = in_valid. Top level holds counters, cfg latch, column registers and output registers.
// TESTING
//  1. L=4, stride2=0, CH=8, pixel value = row*4+col on all channels
//     -> 9 windows; first window {0,1,4,5} at (1,1); last {10,11,14,15} at (3,3).
//  2. L=4, stride2=1, same data -> 4 windows: {0,1,4,5}, {2,3,6,7}, {8,9,12,13}, {10,11,14,15}.
//  3. L=14, stride2=1, in_valid toggled 1010... -> same 49 windows and values as continuous input;
//     win_valid never high in a cycle following in_valid=0.
//  4. Change row_len from 28 to 14 at pixel (5,3) -> frame continues with L=28;
//     next frame uses L=14 (13x13 windows with stride2=0).
//  5. Assert rst at pixel (7,9) of an L=28 frame -> outputs zero next edge;
//     after release, the first window is at (1,1) with post-reset data only.
//  6. row_len=1 and row_len=250 -> behave as L=2 and L=224.
//     With LB2X2_FRAME_END_EN, frame_end fires once per frame on window (223,223).

Source files
------------

// File: rtl/lb2x2_pkg.sv
// Shared constants and helpers for the multi-channel 2x2 line buffer.
// Holds the window slot order, the row-length clamp and the counter-width check.
package lb2x2_pkg;

    // Slot index inside one channel's 4*DW window word (TL ends up in the MSBs)
    localparam int SLOT_TL = 3;
    localparam int SLOT_TR = 2;
    localparam int SLOT_BL = 1;
    localparam int SLOT_BR = 0;
    localparam int SLOTS   = 4;

    function automatic int clamp_len(input int v, input int max_len);
        if (v < 2) begin
            return 2;
        end
        if (v > max_len) begin
            return max_len;
        end
        return v;
    endfunction

    // The row/column counters must be able to hold MAX_LEN itself
    function automatic bit len_w_ok(input int len_w, input int max_len);
        return (2 ** len_w) > max_len;
    endfunction

endpackage

// File: rtl/linebuffer_2x2_multich_if.sv
// Pixel stream in / window stream out for linebuffer_2x2_multich.
// Pure streaming: a beat exists when *_valid is high; there is no ready/backpressure.
interface linebuffer_2x2_multich_if #(
    parameter int CH    = 8,
    parameter int DW    = 4,
    parameter int LEN_W = 8
);
    logic                   in_valid;
    logic [CH*DW-1:0]       ifm_in;
    logic                   win_valid;
    logic [CH*4*DW-1:0]     ifm_win;
    logic [LEN_W-1:0]       win_row;
    logic [LEN_W-1:0]       win_col;

    modport master (
        output in_valid,
        output ifm_in,
        input  win_valid,
        input  ifm_win,
        input  win_row,
        input  win_col
    );

    modport slave (
        input  in_valid,
        input  ifm_in,
        output win_valid,
        output ifm_win,
        output win_row,
        output win_col
    );

endinterface

// File: rtl/linebuffer_row_delay.sv
// Runtime-length row delay: output is the word written exactly len enabled cycles ago.
// The pointer wraps at len-1 and restarts at 0 on reset, so it tracks the column counter.
module linebuffer_row_delay #(
    parameter int W       = 32,
    parameter int MAX_LEN = 224,
    parameter int LEN_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [LEN_W-1:0] len,
    input  logic [W-1:0]     din,
    output logic [W-1:0]     dout
);

    localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    logic [W-1:0]  mem [MAX_LEN];
    logic [AW-1:0] ptr;
    logic [AW-1:0] ptr_last;

    assign ptr_last = AW'(len - LEN_W'(1));

    // Read-before-write on the same slot yields the pixel one row back
    assign dout = mem[ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (en) begin
            ptr <= (ptr == ptr_last) ? '0 : ptr + AW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (en) begin
            mem[ptr] <= din;
        end
    end

endmodule

// File: rtl/linebuffer_2x2_multich.sv
// Multi-channel 2x2 sliding-window generator with runtime row length and stride-1/2.
// Optional LB2X2_FRAME_END_EN adds a frame_end pulse on the last window of each frame.
module linebuffer_2x2_multich
    import lb2x2_pkg::*;
#(
    parameter int CH      = 8,
    parameter int DW      = 4,
    parameter int MAX_LEN = 224,
    parameter int LEN_W   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [LEN_W-1:0]     row_len,
    input  logic                 stride2,
    linebuffer_2x2_multich_if.slave bus
`ifdef LB2X2_FRAME_END_EN
    ,
    output logic                 frame_end
`endif
);

    localparam int PW = CH * DW;
    localparam int WW = CH * SLOTS * DW;

    if (!len_w_ok(LEN_W, MAX_LEN)) begin : g_bad_len_w
        $error("LEN_W too narrow for MAX_LEN");
    end

    logic [LEN_W-1:0] cfg_len;
    logic             cfg_s2;
    logic [LEN_W-1:0] row;
    logic [LEN_W-1:0] col;

    logic             accept;
    logic             frame_start;
    logic [LEN_W-1:0] len_now;
    logic             s2_now;
    logic             col_last;
    logic             row_last;
    logic             win_hit;

    logic [PW-1:0]    top_pix;
    logic [PW-1:0]    prev_top;
    logic [PW-1:0]    prev_bot;
    logic [WW-1:0]    win_next;

    assign accept      = bus.in_valid;
    assign frame_start = (row == '0) && (col == '0);

    // The pixel at (0,0) already runs under the freshly captured configuration
    assign len_now  = frame_start ? LEN_W'(clamp_len(int'(row_len), MAX_LEN)) : cfg_len;
    assign s2_now   = frame_start ? stride2 : cfg_s2;
    assign col_last = (col == len_now - LEN_W'(1));
    assign row_last = (row == len_now - LEN_W'(1));
    assign win_hit  = s2_now ? (row[0] & col[0]) : ((row != '0) && (col != '0));

    linebuffer_row_delay #(
        .W       (PW),
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W)
    ) u_row_delay (
        .clk  (clk),
        .rst  (rst),
        .en   (accept),
        .len  (len_now),
        .din  (bus.ifm_in),
        .dout (top_pix)
    );

    always_comb begin
        win_next = '0;
        for (int c = 0; c < CH; c++) begin
            win_next[c*SLOTS*DW + SLOT_TL*DW +: DW] = prev_top[c*DW +: DW];
            win_next[c*SLOTS*DW + SLOT_TR*DW +: DW] = top_pix[c*DW +: DW];
            win_next[c*SLOTS*DW + SLOT_BL*DW +: DW] = prev_bot[c*DW +: DW];
            win_next[c*SLOTS*DW + SLOT_BR*DW +: DW] = bus.ifm_in[c*DW +: DW];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cfg_len       <= LEN_W'(MAX_LEN);
            cfg_s2        <= 1'b0;
            row           <= '0;
            col           <= '0;
            prev_top      <= '0;
            prev_bot      <= '0;
            bus.win_valid <= 1'b0;
            bus.ifm_win   <= '0;
            bus.win_row   <= '0;
            bus.win_col   <= '0;
        end else begin
            bus.win_valid <= 1'b0;
            if (accept) begin
                if (frame_start) begin
                    cfg_len <= len_now;
                    cfg_s2  <= stride2;
                end
                if (col_last) begin
                    col <= '0;
                    row <= row_last ? '0 : row + LEN_W'(1);
                end else begin
                    col <= col + LEN_W'(1);
                end
                prev_top <= top_pix;
                prev_bot <= bus.ifm_in;
                if (win_hit) begin
                    bus.win_valid <= 1'b1;
                    bus.ifm_win   <= win_next;
                    bus.win_row   <= row;
                    bus.win_col   <= col;
                end
            end
        end
    end

`ifdef LB2X2_FRAME_END_EN
    logic [LEN_W-1:0] last_idx;

    // Stride-2 on an odd length drops the final row/column, so the last window sits one earlier
    assign last_idx = (s2_now && len_now[0]) ? len_now - LEN_W'(2) : len_now - LEN_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_end <= 1'b0;
        end else begin
            frame_end <= accept && win_hit && (row == last_idx) && (col == last_idx);
        end
    end
`endif

endmodule

// File: tb/tb_linebuffer_2x2_multich.sv
// Scoreboard bench for linebuffer_2x2_multich: a position-based pixel model predicts every window.
// Covers reset, stride 1/2, gapped input, mid-frame config change, mid-frame reset and length clamps.
module tb_linebuffer_2x2_multich;

  localparam int CH      = 8;
  localparam int DW      = 4;
  localparam int MAX_LEN = 224;
  localparam int LEN_W   = 8;
  localparam int WW      = CH * 4 * DW;
  localparam int EW      = 1 + WW + 2 * LEN_W;

  logic             clk;
  logic             rst;
  logic [LEN_W-1:0] row_len;
  logic             stride2;
`ifdef LB2X2_FRAME_END_EN
  logic             frame_end;
`endif

  linebuffer_2x2_multich_if #(.CH(CH), .DW(DW), .LEN_W(LEN_W)) bus ();

  linebuffer_2x2_multich #(
    .CH      (CH),
    .DW      (DW),
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .row_len   (row_len),
    .stride2   (stride2),
    .bus       (bus)
`ifdef LB2X2_FRAME_END_EN
    ,
    .frame_end (frame_end)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard state
  logic [EW-1:0]    exp_q[$];
  int               n_cmp;
  int               n_err;
  int               win_cnt;
  int               fe_cnt;
  bit               first_flag;
  logic [WW-1:0]    first_win;
  logic [WW-1:0]    last_win;
  logic [2*LEN_W-1:0] first_pos;
  logic [2*LEN_W-1:0] last_pos;
  logic             iv_edge;

  // bench-side frame model
  int m_row;
  int m_col;
  int m_len;
  int m_off;
  int m_k;
  bit m_s2;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int model_clamp(input int v);
    if (v < 2) return 2;
    if (v > MAX_LEN) return MAX_LEN;
    return v;
  endfunction

  function automatic logic [DW-1:0] pix(input int r, input int c, input int ch);
    return DW'(r * m_len + c + ch * m_k + m_off);
  endfunction

  // driver: one cycle per call, inputs change on the falling edge
  task automatic drive_pixel(input bit v);
    logic [EW-1:0] e;
    logic [WW-1:0] w;
    bit hit;
    bit fe;
    int last;
    @(negedge clk);
    bus.in_valid = v;
    if (!v) begin
      bus.ifm_in = (CH*DW)'($urandom);
      return;
    end
    if (m_row == 0 && m_col == 0) begin
      m_len = model_clamp(int'(row_len));
      m_s2  = stride2;
    end
    for (int ch = 0; ch < CH; ch++) begin
      bus.ifm_in[ch*DW +: DW] = pix(m_row, m_col, ch);
    end
    hit = m_s2 ? ((m_row % 2 == 1) && (m_col % 2 == 1)) : ((m_row >= 1) && (m_col >= 1));
    if (hit) begin
      w = '0;
      for (int ch = 0; ch < CH; ch++) begin
        w[ch*4*DW + 3*DW +: DW] = pix(m_row - 1, m_col - 1, ch);
        w[ch*4*DW + 2*DW +: DW] = pix(m_row - 1, m_col, ch);
        w[ch*4*DW + 1*DW +: DW] = pix(m_row, m_col - 1, ch);
        w[ch*4*DW + 0*DW +: DW] = pix(m_row, m_col, ch);
      end
      last = (m_s2 && (m_len % 2 == 1)) ? m_len - 2 : m_len - 1;
      fe = (m_row == last) && (m_col == last);
      e = {fe, w, LEN_W'(m_row), LEN_W'(m_col)};
      exp_q.push_back(e);
    end
    if (m_col == m_len - 1) begin
      m_col = 0;
      m_row = (m_row == m_len - 1) ? 0 : m_row + 1;
    end else begin
      m_col++;
    end
  endtask

  task automatic run_frame(input bit toggle, input int chg_r, input int chg_c, input int chg_len);
    do begin
      if (m_row == chg_r && m_col == chg_c) row_len = LEN_W'(chg_len);
      drive_pixel(1'b1);
      if (toggle) drive_pixel(1'b0);
    end while (!(m_row == 0 && m_col == 0));
  endtask

  task automatic finish_test(input string name, input int exp_cnt);
    repeat (3) drive_pixel(1'b0);
    check({name, "_count"}, 256'(win_cnt), 256'(exp_cnt));
    check({name, "_drain"}, 256'(exp_q.size()), 256'(0));
  endtask

  task automatic new_test();
    win_cnt    = 0;
    fe_cnt     = 0;
    first_flag = 1'b1;
  endtask

  // monitor: sample 1 time unit after the active edge
  always @(posedge clk) begin
    logic [EW-1:0] e;
    iv_edge = bus.in_valid;
    #1;
    if (!rst && bus.win_valid) begin
      check("gap", 256'(iv_edge), 256'(1));
      win_cnt++;
      if (first_flag) begin
        first_win  = bus.ifm_win;
        first_pos  = {bus.win_row, bus.win_col};
        first_flag = 1'b0;
      end
      last_win = bus.ifm_win;
      last_pos = {bus.win_row, bus.win_col};
      if (exp_q.size() == 0) begin
        check("unexpected_win", 256'(1), 256'(0));
      end else begin
        e = exp_q.pop_front();
        check("win", 256'(bus.ifm_win), 256'(e[2*LEN_W +: WW]));
        check("pos", 256'({bus.win_row, bus.win_col}), 256'(e[2*LEN_W-1:0]));
`ifdef LB2X2_FRAME_END_EN
        check("frame_end", 256'(frame_end), 256'(e[EW-1]));
`endif
      end
    end
`ifdef LB2X2_FRAME_END_EN
    if (!rst && frame_end) begin
      fe_cnt++;
      if (!bus.win_valid) check("frame_end_alone", 256'(1), 256'(0));
    end
`endif
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.ifm_in = '0;
    row_len = 8'd4;
    stride2 = 1'b0;
    m_row = 0; m_col = 0; m_len = MAX_LEN; m_off = 0; m_k = 0; m_s2 = 1'b0;
    new_test();

    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 256'(bus.win_valid), 256'(0));
    check("rst_win", 256'(bus.ifm_win), 256'(0));
    check("rst_pos", 256'({bus.win_row, bus.win_col}), 256'(0));
    @(negedge clk);
    rst = 1'b0;

    // 1: L=4 stride 1, value = row*4+col on every channel
    row_len = 8'd4; stride2 = 1'b0; m_off = 0; m_k = 0;
    run_frame(1'b0, -1, -1, 0);
    finish_test("t1", 9);
    check("t1_first", 256'(first_win), 256'({8{16'h0145}}));
    check("t1_first_pos", 256'(first_pos), 256'({8'd1, 8'd1}));
    check("t1_last", 256'(last_win), 256'({8{16'hABEF}}));
    check("t1_last_pos", 256'(last_pos), 256'({8'd3, 8'd3}));
    new_test();

    // 2: L=4 stride 2
    stride2 = 1'b1;
    run_frame(1'b0, -1, -1, 0);
    finish_test("t2", 4);
    check("t2_first", 256'(first_win), 256'({8{16'h0145}}));
    check("t2_last", 256'(last_win), 256'({8{16'hABEF}}));
    new_test();

    // 3: L=14 stride 2, every other cycle idle
    row_len = 8'd14; stride2 = 1'b1; m_off = 5; m_k = 3;
    run_frame(1'b1, -1, -1, 0);
    finish_test("t3", 49);
    new_test();

    // 4: row_len changes mid-frame; takes effect on the next frame only
    row_len = 8'd28; stride2 = 1'b0; m_off = 1; m_k = 5;
    run_frame(1'b0, 5, 3, 14);
    finish_test("t4a", 729);
    new_test();
    run_frame(1'b0, -1, -1, 0);
    finish_test("t4b", 169);
    check("t4b_first_pos", 256'(first_pos), 256'({8'd1, 8'd1}));
    check("t4b_last_pos", 256'(last_pos), 256'({8'd13, 8'd13}));
    new_test();

    // 5: reset at pixel (7,9) of an L=28 frame
    row_len = 8'd28; stride2 = 1'b0; m_off = 9; m_k = 7;
    while (!(m_row == 7 && m_col == 9)) drive_pixel(1'b1);
    @(negedge clk);
    rst = 1'b1;
    bus.in_valid = 1'b0;
    #1;
    check("t5_rst_valid", 256'(bus.win_valid), 256'(0));
    check("t5_rst_win", 256'(bus.ifm_win), 256'(0));
    check("t5_rst_pos", 256'({bus.win_row, bus.win_col}), 256'(0));
    check("t5_rst_q", 256'(exp_q.size()), 256'(0));
    m_row = 0; m_col = 0;
    @(negedge clk);
    rst = 1'b0;
    new_test();
    m_off = 2;
    run_frame(1'b0, -1, -1, 0);
    finish_test("t5", 729);
    check("t5_first_pos", 256'(first_pos), 256'({8'd1, 8'd1}));
    new_test();

    // 6: length clamps
    row_len = 8'd1; stride2 = 1'b0; m_off = 4; m_k = 1;
    run_frame(1'b0, -1, -1, 0);
    finish_test("t6a", 1);
    check("t6a_pos", 256'(first_pos), 256'({8'd1, 8'd1}));
`ifdef LB2X2_FRAME_END_EN
    check("t6a_fe_count", 256'(fe_cnt), 256'(1));
`endif
    new_test();
    row_len = 8'd250; m_off = 3; m_k = 2;
    run_frame(1'b0, -1, -1, 0);
    finish_test("t6b", 223 * 223);
    check("t6b_last_pos", 256'(last_pos), 256'({8'd223, 8'd223}));
`ifdef LB2X2_FRAME_END_EN
    check("t6b_fe_count", 256'(fe_cnt), 256'(1));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
